lane_to_fifo_bridge: RTL

//  Receive-side counterpart of the TX FIFO-to-lane path. Takes bytes from a lane receiver
//  (LP bus-turnaround read responses, HS loopback) and writes them as framed words to an

---
 rtl/lane_to_fifo_bridge_if.sv | 28 ++
 rtl/lane_to_fifo_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lane_to_fifo_bridge_if.sv
// Lane-receive byte stream and FIFO write port bundle.
// master: bridge side (consumes rx_*, drives fifo_*); slave: environment side.
interface lane_to_fifo_bridge_if;
  logic        rx_active;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [10:0] fifo_wdata;
  logic        fifo_write;
  logic        fifo_full;

  modport master (
    input  rx_active,
    input  rx_valid,
    input  rx_data,
    input  fifo_full,
    output fifo_wdata,
    output fifo_write
  );

  modport slave (
    output rx_active,
    output rx_valid,
    output rx_data,
    output fifo_full,
    input  fifo_wdata,
    input  fifo_write
  );
endinterface

// File: rtl/lane_to_fifo_bridge.sv
// Frames lane bytes into {err,eop,sop,data} FIFO words, drops on overflow.
// Ports: clk, rst_n (sync, low), bus (master), clr_status, overflow, pkt_cnt, drop_cnt, last_len.
module lane_to_fifo_bridge #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lane_to_fifo_bridge_if.master bus,
  input  logic                 clr_status,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [LEN_WIDTH-1:0] last_len
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_TAIL  = 3'd2;
  localparam logic [2:0] S_DROP  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]           state, state_n;
  logic                 rx_active_d;
  logic [7:0]           hold_data, hold_data_n;
  logic                 hold_vld, hold_vld_n;
  logic                 hold_sop, hold_sop_n;
  logic                 sop_written, sop_written_n;
  logic [LEN_WIDTH-1:0] len, len_n, len_inc;

  logic start, fall, byte_in;
  logic wr, eop, term;
  logic pkt_inc, drop_start, drop_end, ovf_set;
  logic [1:0] drop_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [1:0]           b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign start   = bus.rx_active & ~rx_active_d;
  assign fall    = ~bus.rx_active & rx_active_d;
  assign byte_in = bus.rx_active & bus.rx_valid;
  assign len_inc = (&len) ? len : len + LEN_WIDTH'(1);

  assign drop_inc = {1'b0, drop_start} + {1'b0, drop_end};

  // Writes are suppressed while reset is asserted so an abandoned
  // packet never leaks a word out of the hold register.
  assign bus.fifo_write = wr & rst_n;
  assign bus.fifo_wdata = term ? 11'h600
                               : {1'b0, eop, hold_sop, hold_data};

  always_comb begin
    state_n       = state;
    hold_data_n   = hold_data;
    hold_vld_n    = hold_vld;
    hold_sop_n    = hold_sop;
    sop_written_n = sop_written;
    len_n         = len;
    wr            = 1'b0;
    eop           = 1'b0;
    term          = 1'b0;
    pkt_inc       = 1'b0;
    drop_start    = 1'b0;
    drop_end      = 1'b0;
    ovf_set       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n       = S_RECV;
          len_n         = '0;
          sop_written_n = 1'b0;
          hold_vld_n    = 1'b0;
          if (byte_in) begin
            hold_vld_n  = 1'b1;
            hold_sop_n  = 1'b1;
            hold_data_n = bus.rx_data;
            len_n       = LEN_WIDTH'(1);
          end
        end
      end
      S_RECV: begin
        if (fall) begin
          if (hold_vld) begin
            eop = 1'b1;
            wr  = ~bus.fifo_full;
            if (!bus.fifo_full) begin
              state_n    = S_IDLE;
              hold_vld_n = 1'b0;
              pkt_inc    = 1'b1;
            end else begin
              state_n = S_TAIL;
            end
          end else begin
            state_n = S_IDLE;
          end
        end else if (byte_in) begin
          if (!hold_vld) begin
            hold_vld_n  = 1'b1;
            hold_sop_n  = ~sop_written;
            hold_data_n = bus.rx_data;
            len_n       = len_inc;
          end else if (!bus.fifo_full) begin
            wr = 1'b1;
            if (hold_sop) sop_written_n = 1'b1;
            hold_sop_n  = 1'b0;
            hold_data_n = bus.rx_data;
            len_n       = len_inc;
          end else begin
            ovf_set    = 1'b1;
            state_n    = S_DROP;
            hold_vld_n = 1'b0;
          end
        end
      end
      S_TAIL: begin
        eop        = 1'b1;
        wr         = ~bus.fifo_full;
        drop_start = start;
        if (!bus.fifo_full) begin
          state_n    = S_IDLE;
          hold_vld_n = 1'b0;
          pkt_inc    = 1'b1;
        end
      end
      S_DROP: begin
        if (fall) begin
          // Only terminate in the FIFO if the consumer saw a sop.
          if (sop_written) begin
            state_n = S_FLUSH;
          end else begin
            state_n  = S_IDLE;
            drop_end = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        term       = 1'b1;
        wr         = ~bus.fifo_full;
        drop_start = start;
        if (!bus.fifo_full) begin
          state_n  = S_IDLE;
          drop_end = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Tracks the lane even through reset, so a packet already in
  // flight at release is not mistaken for a fresh start.
  always_ff @(posedge clk) begin
    rx_active_d <= bus.rx_active;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hold_data   <= '0;
      hold_vld    <= 1'b0;
      hold_sop    <= 1'b0;
      sop_written <= 1'b0;
      len         <= '0;
    end else begin
      state       <= state_n;
      hold_data   <= hold_data_n;
      hold_vld    <= hold_vld_n;
      hold_sop    <= hold_sop_n;
      sop_written <= sop_written_n;
      len         <= len_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      last_len <= '0;
    end else begin
      if (pkt_inc) last_len <= len;
      if (clr_status) begin
        overflow <= 1'b0;
        pkt_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        if (ovf_set) overflow <= 1'b1;
        pkt_cnt  <= sat_add(pkt_cnt, {1'b0, pkt_inc});
        drop_cnt <= sat_add(drop_cnt, drop_inc);
      end
    end
  end

endmodule
